// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : Receive side of the 8N1 UART link. Oversamples the serial line on
//            sample_tick, rebuilds each byte LSB first, and hands it to the
//            consumer through a one-deep holding register with a
//            ready/acknowledge handshake. Framing and overrun errors are sticky.
// Ports    : clk          system clock (rising edge)
//            rstn         asynchronous active-low reset
//            serial_in    asynchronous UART line, idle high
//            sample_tick  one-clk strobe at OVS x baud
//            rd_ack       consumer took data_out; clears rx_ready and errors
//            data_out     last correctly received byte
//            rx_ready     data_out holds an unread byte
//            frame_err    sticky, stop bit sampled 0
//            overrun_err  sticky, frame completed while rx_ready was set
//            parity_err   sticky, even-parity mismatch (UART_RX_PARITY_EN only)
// Options  : define UART_RX_PARITY_EN for frames carrying an even-parity bit
//            between the last data bit and the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_in,
  input  logic                 sample_tick,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_ready,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun_err
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 sync1;
  logic                 rx_s;
  logic                 armed;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '1;
      armed       <= 1'b0;
      data_out    <= '0;
      rx_ready    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
      par_bad     <= 1'b0;
`endif
    end else begin
      // Acknowledge clears first; a frame completing in the same cycle
      // overrides these assignments further down.
      if (rd_ack) begin
        rx_ready    <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err  <= 1'b0;
`endif
      end

      if (sample_tick) begin
        case (state)
          IDLE: begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            // A line held low after a bad stop bit must go high once
            // before a new start edge is accepted.
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state <= START;
            end
          end

          START: begin
            if (tick_cnt == TICK_HALF) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              // Line back high at mid start bit: treat as a glitch.
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              // Shift right from the MSB so the first bit lands in bit 0.
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              par_bad  <= ^{shreg, rx_s};
              if (^{shreg, rx_s}) begin
                parity_err <= 1'b1;
              end
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`endif

          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= IDLE;
              armed    <= rx_s;
`ifdef UART_RX_PARITY_EN
              // Keep this frame's parity error even if rd_ack lands now.
              if (par_bad) begin
                parity_err <= 1'b1;
              end
`endif
              if (!rx_s) begin
                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (!par_bad) begin
`else
              end else begin
`endif
                // An acknowledge in this very cycle frees the holding
                // register, so the new byte is accepted without overrun.
                if (!rx_ready || rd_ack) begin
                  data_out <= shreg;
                  rx_ready <= 1'b1;
                end else begin
                  overrun_err <= 1'b1;
                end
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
